// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and occupancy encodings for pipeline stage registers
package pipe_pkg;

  localparam int              CTRL_W_DEF   = 15;
  localparam logic [14:0]     CTRL_NOP_DEF = 15'd1;

  // Occupancy doubles as the stage FSM state and is exported unchanged.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // in_ready is registered from the next occupancy: ready while fewer than two entries held.
  function automatic logic occ_has_room(input occ_t occ);
    return (occ != OCC_FULL);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one ctrl+data pipeline entry with async reset, load and clear-to-NOP
// Ports:
//   clk     in   1       clock, rising edge
//   reset   in   1       asynchronous, active-low; entry becomes CTRL_NOP / 0
//   load    in   1       capture d_ctrl / d_data
//   clear   in   1       synchronous clear to CTRL_NOP / 0, wins over load
//   d_ctrl  in   CTRL_W  control bundle to capture
//   d_data  in   DATA_W  payload to capture
//   q_ctrl  out  CTRL_W  held control bundle
//   q_data  out  DATA_W  held payload
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W   = CTRL_W_DEF,
  parameter int                 DATA_W   = 128,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_ctrl <= CTRL_NOP;
      q_data <= '0;
    end else if (clear) begin
      q_ctrl <= CTRL_NOP;
      q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with 2-entry skid and flush
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-low
//   flush      in   1       synchronous flush, discards every held entry
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage can accept (registered, skid entry empty)
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       main entry valid
//   out_ready  in   1       downstream accepts
//   out_ctrl   out  CTRL_W  control bundle to next stage
//   out_data   out  DATA_W  payload to next stage
//   occupancy  out  2       entries held: 0, 1 or 2
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 128,
  parameter int                 CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]  CTRL_NOP    = CTRL_W'(CTRL_NOP_DEF),
  parameter bit                 ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_t state;
  occ_t state_nxt;

  logic accept;
  logic deliver;

  logic main_load;
  logic main_from_skid;
  logic main_clear;
  logic skid_load;
  logic skid_clear;

  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] skid_q_ctrl;
  logic [DATA_W-1:0] skid_q_data;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != OCC_EMPTY);
  assign deliver   = out_valid & out_ready;
  assign occupancy = state;

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      // Flush outranks both handshakes; an entry offered this cycle is dropped.
      state_nxt  = OCC_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            state_nxt = OCC_ONE;
            main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && deliver) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_nxt = OCC_FULL;
            skid_load = 1'b1;
          end else if (deliver) begin
            state_nxt  = OCC_EMPTY;
            main_clear = ZERO_BUBBLE;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a deliver can move the state;
          // the older skid entry slides into main before anything newer.
          if (deliver) begin
            state_nxt      = OCC_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_nxt  = OCC_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= OCC_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= occ_has_room(state_nxt);
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_q_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_q_data : in_data;

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_ctrl (out_ctrl),
    .q_data (out_data)
  );

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_ctrl (skid_q_ctrl),
    .q_data (skid_q_data)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DW = 128;
  localparam int CW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic          z_in_ready;
  logic          z_out_valid;
  logic [CW-1:0] z_out_ctrl;
  logic [DW-1:0] z_out_data;
  logic [1:0]    z_occupancy;

  int total = 0;
  int bad   = 0;

  logic [CW+DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(15'd1), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(15'd1), .ZERO_BUBBLE(1'b0)) dut_hold (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .occupancy(z_occupancy)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: handshakes are judged at negedge from values that stay stable to the next posedge.
  always @(negedge clk) begin
    if (!reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got=%0h want=none", {out_ctrl, out_data});
        end else begin
          check("sb_deliver", {out_ctrl, out_data}, sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
    end
  end

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic          eir;
    logic [1:0]    eocc;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                              input logic ordy, input logic fl, input logic ev, input logic eir,
                              input logic [1:0] eocc, input logic [CW-1:0] ec, input logic [DW-1:0] ed);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.eir = eir; v.eocc = eocc; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"},  in_ready,  1'b1);
    check({tag, "_occ"},       occupancy, 2'd0);
    check({tag, "_ctrl"},      out_ctrl,  15'd1);
    check({tag, "_data"},      out_data,  128'd0);
    check({tag, "_hold_ctrl"}, z_out_ctrl, 15'd1);
    check({tag, "_hold_data"}, z_out_data, 128'd0);
  endtask

  initial begin
    //                iv  ctrl   data    ordy fl  ev  eir occ ectrl  edata
    vecs[0]  = mk(1, 15'd5, 'hA,   1, 0,  1,  1, 2'd1, 15'd5, 'hA);
    vecs[1]  = mk(1, 15'd6, 'hB,   1, 0,  1,  1, 2'd1, 15'd6, 'hB);
    vecs[2]  = mk(1, 15'd7, 'hC,   1, 0,  1,  1, 2'd1, 15'd7, 'hC);
    vecs[3]  = mk(0, 15'd0, 'h0,   1, 0,  0,  1, 2'd0, 15'd1, 'h0);
    vecs[4]  = mk(1, 15'd2, 'h11,  0, 0,  1,  1, 2'd1, 15'd2, 'h11);
    vecs[5]  = mk(1, 15'd3, 'h22,  0, 0,  1,  0, 2'd2, 15'd2, 'h11);
    vecs[6]  = mk(1, 15'd4, 'h33,  0, 0,  1,  0, 2'd2, 15'd2, 'h11);
    vecs[7]  = mk(1, 15'd4, 'h33,  1, 0,  1,  1, 2'd1, 15'd3, 'h22);
    vecs[8]  = mk(1, 15'd4, 'h33,  1, 0,  1,  1, 2'd1, 15'd4, 'h33);
    vecs[9]  = mk(0, 15'd0, 'h0,   1, 0,  0,  1, 2'd0, 15'd1, 'h0);
    vecs[10] = mk(1, 15'd2, 'h11,  0, 0,  1,  1, 2'd1, 15'd2, 'h11);
    vecs[11] = mk(1, 15'd3, 'h22,  0, 0,  1,  0, 2'd2, 15'd2, 'h11);
    vecs[12] = mk(1, 15'd8, 'h44,  0, 1,  0,  1, 2'd0, 15'd1, 'h0);
    vecs[13] = mk(0, 15'd0, 'h0,   1, 0,  0,  1, 2'd0, 15'd1, 'h0);
    vecs[14] = mk(1, 15'd9, 'h55,  0, 0,  1,  1, 2'd1, 15'd9, 'h55);
    vecs[15] = mk(1, 15'd8, 'h44,  0, 1,  0,  1, 2'd0, 15'd1, 'h0);
    vecs[16] = mk(0, 15'd0, 'h0,   1, 0,  0,  1, 2'd0, 15'd1, 'h0);

    // Reset held with random inputs toggling.
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    for (int r = 0; r < 4; r++) begin
      step();
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    check_reset_vals("rst");

    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1 reset = 1'b1;

    // Table: streaming, back-pressure, flush at FULL and flush of an accepting cycle.
    for (int i = 0; i < 17; i++) begin
      in_valid  = vecs[i].iv;
      in_ctrl   = vecs[i].ic;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ev);
      check($sformatf("v%0d_in_ready", i),  in_ready,  vecs[i].eir);
      check($sformatf("v%0d_occ", i),       occupancy, vecs[i].eocc);
      check($sformatf("v%0d_ctrl", i),      out_ctrl,  vecs[i].ec);
      check($sformatf("v%0d_data", i),      out_data,  vecs[i].ed);
    end
    flush = 1'b0;

    // Deliver-to-empty: zeroing build shows NOP/0, holding build keeps the last entry.
    in_valid = 1'b1; in_ctrl = 15'h1234; in_data = 'h66; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("zb1_valid", out_valid, 1'b0);
    check("zb1_data",  out_data,  128'd0);
    check("zb1_ctrl",  out_ctrl,  15'd1);
    check("zb0_valid", z_out_valid, 1'b0);
    check("zb0_data",  z_out_data,  128'h66);
    check("zb0_ctrl",  z_out_ctrl,  15'h1234);

    // Async reset between edges while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 15'd2; in_data = 'h11;
    step();
    in_ctrl = 15'd3; in_data = 'h22;
    step();
    in_valid = 1'b0;
    check("pre_arst_occ", occupancy, 2'd2);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("arst");
    @(posedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b1; in_ctrl = 15'd5; in_data = 'h55; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_arst_valid", out_valid, 1'b1);
    check("post_arst_data",  out_data,  128'h55);
    check("post_arst_occ",   occupancy, 2'd1);
    step();
    check("post_arst_alone", out_valid, 1'b0);
    check("post_arst_occ0",  occupancy, 2'd0);

    repeat (2) step();
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
